// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: active-high code table (bit6=a .. bit0=g)
// and the capture output FSM states. Also used by the display encoder.
package seg_pkg;

   localparam logic [6:0] SEG_0     = 7'h7E;
   localparam logic [6:0] SEG_1     = 7'h30;
   localparam logic [6:0] SEG_2     = 7'h6D;
   localparam logic [6:0] SEG_3     = 7'h79;
   localparam logic [6:0] SEG_4     = 7'h33;
   localparam logic [6:0] SEG_5     = 7'h5B;
   localparam logic [6:0] SEG_6     = 7'h5F;
   localparam logic [6:0] SEG_7     = 7'h70;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h7B;
   localparam logic [6:0] SEG_A     = 7'h77;
   localparam logic [6:0] SEG_B     = 7'h1F;
   localparam logic [6:0] SEG_C     = 7'h4E;
   localparam logic [6:0] SEG_D     = 7'h3D;
   localparam logic [6:0] SEG_E     = 7'h4F;
   localparam logic [6:0] SEG_F     = 7'h47;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   typedef enum logic [0:0] {
      SCAN = 1'b0,
      HOLD = 1'b1
   } fsm_state_e;

endpackage

// File: rtl/seven_seg_capture_if.sv
// Frame output channel of the seven-segment capture block: value plus a
// valid/ready handshake.
interface seven_seg_capture_if #(
   parameter int NUM_DIGITS = 8
);
   logic [4*NUM_DIGITS-1:0] value;
   logic                    out_valid;
   logic                    out_ready;

   modport master (output value, output out_valid, input out_ready);
   modport slave  (input value, input out_valid, output out_ready);
endinterface

// File: rtl/seg7_decode.sv
// Combinational seven-segment pattern to hex nibble decoder; hit is set only
// for one of the 16 table codes, blank flags the all-off gap pattern.
module seg7_decode
   import seg_pkg::*;
(
   input  logic [6:0] seg,
   output logic       hit,
   output logic       blank,
   output logic [3:0] nibble
);

   always_comb begin
      hit    = 1'b1;
      blank  = (seg == SEG_BLANK);
      nibble = 4'h0;
      case (seg)
         SEG_0:   nibble = 4'h0;
         SEG_1:   nibble = 4'h1;
         SEG_2:   nibble = 4'h2;
         SEG_3:   nibble = 4'h3;
         SEG_4:   nibble = 4'h4;
         SEG_5:   nibble = 4'h5;
         SEG_6:   nibble = 4'h6;
         SEG_7:   nibble = 4'h7;
         SEG_8:   nibble = 4'h8;
         SEG_9:   nibble = 4'h9;
         SEG_A:   nibble = 4'hA;
         SEG_B:   nibble = 4'hB;
         SEG_C:   nibble = 4'hC;
         SEG_D:   nibble = 4'hD;
         SEG_E:   nibble = 4'hE;
         SEG_F:   nibble = 4'hF;
         default: hit    = 1'b0;
      endcase
   end

endmodule

// File: rtl/seven_seg_capture.sv
// Receive side of a multiplexed seven-segment display: debounces the shared
// segment bus per digit, rebuilds a full frame and hands it out via valid/ready.
module seven_seg_capture
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS    = 8,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [6:0]            seg,
   input  logic [NUM_DIGITS-1:0] dig_sel,
   seven_seg_capture_if.master   frame,
   output logic                  code_err,
   output logic                  sel_err,
   output logic                  overrun
);

   localparam int SW = NUM_DIGITS + 7;
   localparam int VW = 4 * NUM_DIGITS;
   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
   localparam logic [0:0] ST_SCAN = 1'(SCAN);
   localparam logic [0:0] ST_HOLD = 1'(HOLD);

   function automatic logic is_onehot(input logic [NUM_DIGITS-1:0] s);
      return (s != '0) && ((s & (s - 1'b1)) == '0);
   endfunction

   logic [SW-1:0]         samp_p0;
   logic [CW-1:0]         stab_cnt;
   logic [NUM_DIGITS-1:0] got;
   logic [VW-1:0]         cap_buf;
   logic                  frame_pend_p1;
   logic [VW-1:0]         value_r;
   logic [0:0]            state;

   logic                  same;
   logic                  commit;
   logic [NUM_DIGITS-1:0] sel_p0;
   logic                  hit;
   logic                  blank;
   logic [3:0]            nibble;
   logic [NUM_DIGITS-1:0] got_base;
   logic [NUM_DIGITS-1:0] got_nx;
   logic [VW-1:0]         buf_nx;
   logic                  code_err_nx;
   logic                  sel_err_nx;
   logic                  frame_done_nx;
   logic                  out_free;
   logic                  load;

   // Sample stage: the commit fires on the edge that brings stab_cnt to STABLE_CYCLES
   assign same   = ({dig_sel, seg} == samp_p0);
   assign commit = same && (stab_cnt == CNT_LAST);
   assign sel_p0 = samp_p0[SW-1:7];

   seg7_decode u_decode (
      .seg    (samp_p0[6:0]),
      .hit    (hit),
      .blank  (blank),
      .nibble (nibble)
   );

   // Commit stage: update got-mask and buffer; a pending frame clears got first
   always_comb begin
      got_base      = frame_pend_p1 ? '0 : got;
      got_nx        = got_base;
      buf_nx        = cap_buf;
      code_err_nx   = 1'b0;
      sel_err_nx    = 1'b0;
      if (commit) begin
         if (!is_onehot(sel_p0)) begin
            sel_err_nx = 1'b1;
         end else if (blank) begin
            got_nx = got_base;
         end else if (!hit) begin
            code_err_nx = 1'b1;
            got_nx      = got_base & ~sel_p0;
         end else begin
            got_nx = got_base | sel_p0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
               if (sel_p0[i]) buf_nx[4*i +: 4] = nibble;
            end
         end
      end
      frame_done_nx = commit && (&got_nx);
   end

   // Load stage: a completed frame moves out when the slot is empty or being drained
   assign out_free = (state == ST_SCAN) || frame.out_ready;
   assign load     = frame_pend_p1 && out_free;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         samp_p0       <= '0;
         stab_cnt      <= '0;
         got           <= '0;
         cap_buf       <= '0;
         frame_pend_p1 <= 1'b0;
         value_r       <= '0;
         state         <= ST_SCAN;
         code_err      <= 1'b0;
         sel_err       <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         samp_p0 <= {dig_sel, seg};
         if (!same)                   stab_cnt <= '0;
         else if (stab_cnt != CNT_MAX) stab_cnt <= stab_cnt + 1'b1;
         got           <= got_nx;
         cap_buf       <= buf_nx;
         frame_pend_p1 <= frame_done_nx;
         code_err      <= code_err_nx;
         sel_err       <= sel_err_nx;
         overrun       <= frame_pend_p1 && !out_free;
         if (load) value_r <= cap_buf;
         case (state)
            ST_SCAN: if (load) state <= ST_HOLD;
            ST_HOLD: if (frame.out_ready && !load) state <= ST_SCAN;
            default: state <= ST_SCAN;
         endcase
      end
   end

   assign frame.value     = value_r;
   assign frame.out_valid = (state == ST_HOLD);

endmodule

// File: tb/tb_seven_seg_capture.sv
// Scoreboard bench for seven_seg_capture: expected frames are queued as they
// are driven and popped when the DUT hands a frame over.
module tb_seven_seg_capture;

   localparam int ND = 8;
   localparam int SC = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [6:0]    seg;
   logic [ND-1:0] dig_sel;
   logic          code_err, sel_err, overrun;

   seven_seg_capture_if #(.NUM_DIGITS(ND)) frame_if ();

   seven_seg_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
      .clk      (clk),
      .rst      (rst),
      .seg      (seg),
      .dig_sel  (dig_sel),
      .frame    (frame_if),
      .code_err (code_err),
      .sel_err  (sel_err),
      .overrun  (overrun)
   );

   always #5 clk = ~clk;

   logic [6:0] seg_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

   int          n_checks = 0;
   int          n_errors = 0;
   int          n_code = 0, n_sel = 0, n_ovr = 0;
   logic [31:0] exp_q [$];

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Monitor at the falling edge: sees the values the next rising edge will act on
   always @(negedge clk) begin
      if (!rst) begin
         if (code_err) n_code++;
         if (sel_err)  n_sel++;
         if (overrun)  n_ovr++;
         if (frame_if.out_valid && frame_if.out_ready) begin
            if (exp_q.size() == 0) check("frame_q_nonempty", 32'(exp_q.size()), 32'd1);
            else                   check("frame_value", frame_if.value, exp_q.pop_front());
         end
      end
   end

   task automatic put(input logic [ND-1:0] sel, input logic [6:0] s, input int n);
      @(posedge clk); #1;
      dig_sel = sel;
      seg     = s;
      repeat (n - 1) @(posedge clk);
   endtask

   task automatic idle();
      put(8'h01, 7'h00, 2);
   endtask

   task automatic send_digit(input int i, input logic [31:0] v, input int n);
      put(8'(1 << i), seg_tab[v[4*i +: 4]], n);
   endtask

   task automatic send_frame(input logic [31:0] v, input bit gap);
      for (int i = 0; i < ND; i++) begin
         send_digit(i, v, 6);
         if (gap) put(8'(1 << i), 7'h00, 6);
      end
   endtask

   task automatic wait_valid(input string tag);
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (frame_if.out_valid) break;
      end
      check(tag, 32'(frame_if.out_valid), 32'd1);
   endtask

   task automatic accept();
      @(posedge clk); #1 frame_if.out_ready = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (frame_if.out_valid) break;
      end
      check("accept_valid", 32'(frame_if.out_valid), 32'd1);
      @(posedge clk); #1 frame_if.out_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, s0, o0;
      logic [31:0] v2, fa, fb;
      v2 = 32'h9876_E210;
      fa = 32'hDEAD_BEEF;
      fb = 32'h0BAD_F00D;

      rst = 1'b1;
      frame_if.out_ready = 1'b0;
      dig_sel = 8'h01;
      seg = 7'h00;
      repeat (3) @(posedge clk); #1;
      check("rst_value", frame_if.value, 32'h0);
      check("rst_valid", 32'(frame_if.out_valid), 32'd0);
      check("rst_errs", 32'({code_err, sel_err, overrun}), 32'd0);
      rst = 1'b0;

      // 1: plain frame, held until accepted
      send_frame(32'h1234_5678, 1'b0);
      exp_q.push_back(32'h1234_5678);
      idle();
      wait_valid("t1_valid");
      check("t1_value", frame_if.value, 32'h1234_5678);
      repeat (5) @(posedge clk); #1;
      check("t1_hold_valid", 32'(frame_if.out_valid), 32'd1);
      check("t1_hold_value", frame_if.value, 32'h1234_5678);
      accept();
      @(negedge clk);
      check("t1_released", 32'(frame_if.out_valid), 32'd0);

      // 2: bad code clears got[3], then a good E completes the frame
      c0 = n_code;
      send_digit(3, 32'h0, 6);
      put(8'h08, 7'h01, 6);
      idle();
      check("t2_code_err", 32'(n_code - c0), 32'd1);
      for (int i = 0; i < ND; i++) if (i != 3) send_digit(i, v2, 6);
      idle();
      repeat (10) @(posedge clk); #1;
      check("t2_no_frame", 32'(frame_if.out_valid), 32'd0);
      exp_q.push_back(v2);
      put(8'h08, 7'h4F, 6);
      idle();
      wait_valid("t2_valid");
      check("t2_value", frame_if.value, v2);
      accept();

      // 3: select errors
      s0 = n_sel;
      put(8'b0000_0011, seg_tab[5], 6);
      idle();
      check("t3_sel_two", 32'(n_sel - s0), 32'd1);
      put(8'h00, seg_tab[5], 6);
      idle();
      check("t3_sel_zero", 32'(n_sel - s0), 32'd2);
      check("t3_no_valid", 32'(frame_if.out_valid), 32'd0);
      check("t3_value", frame_if.value, v2);

      // 4: glitching bus never commits
      c0 = n_code;
      s0 = n_sel;
      for (int k = 0; k < 10; k++)
         put((k % 2) ? 8'h03 : 8'h04, (k % 2) ? 7'h01 : 7'h02, 2);
      idle();
      check("t4_code", 32'(n_code - c0), 32'd0);
      check("t4_sel", 32'(n_sel - s0), 32'd0);

      // 5: frame A with blank gaps, B dropped, then B with simultaneous accept
      c0 = n_code;
      s0 = n_sel;
      send_frame(fa, 1'b1);
      exp_q.push_back(fa);
      idle();
      wait_valid("t5_valid_a");
      check("t5_value_a", frame_if.value, fa);
      check("t5_gap_errs", 32'((n_code - c0) + (n_sel - s0)), 32'd0);
      o0 = n_ovr;
      send_frame(fb, 1'b0);
      idle();
      repeat (3) @(posedge clk); #1;
      check("t5_overrun", 32'(n_ovr - o0), 32'd1);
      check("t5_keep_a", frame_if.value, fa);
      check("t5_keep_valid", 32'(frame_if.out_valid), 32'd1);
      exp_q.push_back(fb);
      for (int i = 0; i < ND - 1; i++) send_digit(i, fb, 6);
      send_digit(ND - 1, fb, 1);
      repeat (SC + 1) @(posedge clk); #1 frame_if.out_ready = 1'b1;
      @(posedge clk); #1 frame_if.out_ready = 1'b0;
      @(negedge clk);
      check("t5_b_valid", 32'(frame_if.out_valid), 32'd1);
      check("t5_b_value", frame_if.value, fb);
      check("t5_no_overrun", 32'(n_ovr - o0), 32'd1);

      // 6: asynchronous reset mid-frame with B still held
      for (int i = 0; i < 5; i++) send_digit(i, 32'h7654_3210, 6);
      @(negedge clk); #2 rst = 1'b1;
      #1;
      check("t6_rst_value", frame_if.value, 32'h0);
      check("t6_rst_valid", 32'(frame_if.out_valid), 32'd0);
      exp_q.delete();
      repeat (2) @(posedge clk); #1 rst = 1'b0;
      for (int i = 5; i < ND; i++) send_digit(i, 32'h7654_3210, 6);
      idle();
      repeat (10) @(posedge clk); #1;
      check("t6_no_frame", 32'(frame_if.out_valid), 32'd0);
      check("t6_value", frame_if.value, 32'h0);
      check("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
